seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand/result width in bits (legal range 4..64).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operation request present.
REQ-005 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have ports operandA and operandB  input  WIDTH each  operands, two's complement where signed.
REQ-007 SHALL have port command  input  4  opcode: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR, 8 MUL.
REQ-008 SHALL have port out_valid  output  1  result registers hold a completed operation.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-010 SHALL have ports result  output  WIDTH, carryout, zero and overflow  output  1 each  registered result and flags.

Function
REQ-011 SHALL implement states IDLE, BUSY and DONE.
REQ-012 SHALL drive in_ready=1 in IDLE, and in DONE when out_ready=1; 0 otherwise.
REQ-013 SHALL accept a request on an edge with in_valid=1 and in_ready=1, capturing operandA, operandB and command; inputs SHALL be ignored at all other times.
REQ-014 Opcodes 0-7 and undefined opcodes SHALL complete in one cycle: accept at edge N -> DONE, out_valid=1 after edge N.
REQ-015 ADD: result=(A+B) mod 2^WIDTH; carryout=carry out of MSB; overflow=signed overflow.
REQ-016 SUB: result=(A+~B+1) mod 2^WIDTH; carryout=carry out of MSB (1 = no borrow); overflow=signed overflow.
REQ-017 SLT: result=1 if A<B signed, else 0 (upper bits 0); carryout=0, overflow=0.
REQ-018 XOR/AND/NAND/NOR/OR: bitwise over WIDTH bits; carryout=0, overflow=0.
REQ-019 For every opcode, zero SHALL be 1 exactly when result==0.
REQ-020 Undefined opcodes SHALL yield result=0, zero=1, carryout=0, overflow=0.
REQ-021 In DONE, result and flags SHALL stay stable until the edge with out_ready=1; on that edge, the block SHALL go to IDLE, or, when a new request is accepted on that same edge, load it (BUSY for MUL, DONE otherwise) without a bubble.
REQ-022 out_valid SHALL be 1 only in DONE.

Reset
REQ-023 reset=1 SHALL immediately, without waiting for a clock, force state IDLE, result=0, carryout=0, zero=0, overflow=0, out_valid=0; in_ready=1 while reset is low again.
REQ-024 Reset during BUSY or DONE SHALL discard the operation in flight; no result SHALL be presented afterward.

Configuration
REQ-025 Macro SEQ_ALU_MUL_EN SHALL control opcode 8 (MUL).
REQ-026 With SEQ_ALU_MUL_EN defined: MUL is unsigned shift-add, one partial product per cycle; accept at edge N -> BUSY for WIDTH edges -> DONE, out_valid=1 after edge N+WIDTH.
REQ-027 With SEQ_ALU_MUL_EN defined: result=low WIDTH bits of A*B; overflow=1 if the high WIDTH bits are nonzero; carryout=0.
REQ-028 Without SEQ_ALU_MUL_EN: no multiplier hardware, BUSY unreachable, opcode 8 treated as undefined per REQ-020.

Verification (WIDTH=32)
REQ-029 ADD 0x7FFFFFFF+0x00000001 -> one cycle later out_valid=1, result=0x80000000, overflow=1, carryout=0, zero=0.
REQ-030 SUB 5-5 -> result=0, zero=1, carryout=1, overflow=0; SLT 0xFFFFFFFF vs 0x00000001 -> result=1.
REQ-031 OR 0xF0F0F0F0|0x0F0F0F0F, out_ready held 0 for 3 cycles -> result=0xFFFFFFFF held stable, in_ready=0; then raise out_ready with an AND request pending -> AND accepted on the same edge, out_valid stays 1 with the new result.
REQ-032 With MUL_EN: MUL 0x00010000*0x00010000 -> out_valid after exactly 32 cycles, result=0, zero=1, overflow=1; MUL 7*6 -> result=42, overflow=0.
REQ-033 With MUL_EN: reset asserted mid-clock at cycle 10 of MUL -> out_valid=0 and outputs 0 immediately, in_ready=1 after release, no stale result later.
REQ-034 Without MUL_EN: command 8 -> result=0, zero=1, out_valid after 1 cycle.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes on both sides and registered result/flags.
// Define SEQ_ALU_MUL_EN to build the WIDTH-cycle shift-add multiplier for opcode 8.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic [3:0]       command,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             zero,
    output logic             overflow,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready may depend combinationally on out_ready so a new request can replace
    // the held result on the same edge it is consumed.
    logic accept;
    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign dbg_state = state;

    logic             sub_op;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    assign sub_op = (command == 4'd1);
    assign b_eff  = sub_op ? ~operandB : operandB;
    assign sum    = {1'b0, operandA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (command)
            4'd0, 4'd1: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                // Operands (after inversion for SUB) agree in sign but the sum does not.
                alu_v   = (operandA[WIDTH-1] == b_eff[WIDTH-1]) &&
                          (sum[WIDTH-1] != operandA[WIDTH-1]);
            end
            4'd2: alu_res = operandA ^ operandB;
            4'd3: alu_res = {{(WIDTH-1){1'b0}}, ($signed(operandA) < $signed(operandB))};
            4'd4: alu_res = operandA & operandB;
            4'd5: alu_res = ~(operandA & operandB);
            4'd6: alu_res = ~(operandA | operandB);
            4'd7: alu_res = operandA | operandB;
            default: alu_res = '0;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic [CW-1:0]    mul_cnt;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_lo_next;

    // {mul_hi, mul_lo} starts as {0, B}; each step adds A to the high half when the
    // current multiplier bit is set, then shifts the whole product right by one.
    assign mul_sum     = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mul_a} : {(WIDTH+1){1'b0}});
    assign mul_lo_next = {mul_sum[0], mul_lo[WIDTH-1:1]};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            result   <= '0;
            carryout <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            mul_a    <= '0;
            mul_hi   <= '0;
            mul_lo   <= '0;
            mul_cnt  <= '0;
`endif
        end
`ifdef SEQ_ALU_MUL_EN
        else if (accept && (command == 4'd8)) begin
            state   <= BUSY;
            mul_a   <= operandA;
            mul_hi  <= '0;
            mul_lo  <= operandB;
            mul_cnt <= '0;
        end
`endif
        else if (accept) begin
            state    <= DONE;
            result   <= alu_res;
            carryout <= alu_c;
            zero     <= (alu_res == '0);
            overflow <= alu_v;
        end else begin
            case (state)
                BUSY: begin
`ifdef SEQ_ALU_MUL_EN
                    mul_hi  <= mul_sum[WIDTH:1];
                    mul_lo  <= mul_lo_next;
                    mul_cnt <= mul_cnt + 1'b1;
                    if (mul_cnt == CW'(WIDTH - 1)) begin
                        state    <= DONE;
                        result   <= mul_lo_next;
                        carryout <= 1'b0;
                        zero     <= (mul_lo_next == '0);
                        overflow <= (mul_sum[WIDTH:1] != '0);
                    end
`else
                    state <= IDLE;
`endif
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed corner cases plus a randomized
// run compared against a cycle-timed arithmetic reference model.
module tb_seq_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] operandA;
    logic [W-1:0] operandB;
    logic [3:0]   command;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carryout;
    logic         zero;
    logic         overflow;
    logic [1:0]   dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [W+2:0] exp_q[$];

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .operandA(operandA), .operandB(operandB), .command(command),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carryout(carryout), .zero(zero), .overflow(overflow),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference: {result, carryout, zero, overflow} from plain integer arithmetic.
    function automatic logic [W+2:0] model(input logic [3:0] cmd, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         c;
        logic         v;
        longint       sa;
        longint       sb;
        longint       s;
        logic [63:0]  wide;
        r    = '0;
        c    = 1'b0;
        v    = 1'b0;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        wide = 64'(a) + 64'(b);
        case (cmd)
            4'd0: begin
                r = wide[W-1:0];
                c = wide[W];
                s = sa + sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1: begin
                r = a - b;
                c = (a >= b);
                s = sa - sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2: r = a ^ b;
            4'd3: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd4: r = a & b;
            4'd5: r = ~(a & b);
            4'd6: r = ~(a | b);
            4'd7: r = a | b;
`ifdef SEQ_ALU_MUL_EN
            4'd8: begin
                wide = 64'(a) * 64'(b);
                r = wide[W-1:0];
                v = (wide[63:32] != 32'd0);
            end
`endif
            default: r = '0;
        endcase
        return {r, c, (r == '0), v};
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 15));
            default: return 32'($urandom());
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] cmd, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic ordy);
        in_valid  = v;
        command   = cmd;
        operandA  = a;
        operandB  = b;
        out_ready = ordy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 4'd0, '0, '0, 1'b0);
        #2;
        n_cmp++;
        if ({out_valid, result, carryout, zero, overflow} !== '0) begin
            $display("FAIL reset_outputs: got ov=%b res=%h c=%b z=%b v=%b want all 0",
                     out_valid, result, carryout, zero, overflow);
            n_err++;
        end
        n_cmp++;
        if (dbg_state !== 2'd0) begin
            $display("FAIL reset_state: got %0d want 0", dbg_state);
            n_err++;
        end
        tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1/0",
                     in_ready, out_valid);
            n_err++;
        end
    endtask

    task automatic test_add_overflow();
        drive(1'b1, 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || {result, carryout, zero, overflow} !== {32'h8000_0000, 3'b001}) begin
            $display("FAIL add_overflow: got ov=%b res=%h c=%b z=%b v=%b want 1 80000000 0 0 1",
                     out_valid, result, carryout, zero, overflow);
            n_err++;
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            $display("FAIL add_release: got out_valid=%b want 0", out_valid);
            n_err++;
        end
    endtask

    task automatic test_sub_slt();
        drive(1'b1, 4'd1, 32'd5, 32'd5, 1'b0);
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || {result, carryout, zero, overflow} !== {32'h0, 3'b110}) begin
            $display("FAIL sub_zero: got ov=%b res=%h c=%b z=%b v=%b want 1 0 1 1 0",
                     out_valid, result, carryout, zero, overflow);
            n_err++;
        end
        drive(1'b1, 4'd3, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || {result, carryout, zero, overflow} !== {32'h1, 3'b000}) begin
            $display("FAIL slt_signed: got ov=%b res=%h c=%b z=%b v=%b want 1 1 0 0 0",
                     out_valid, result, carryout, zero, overflow);
            n_err++;
        end
        drive(1'b0, 4'd0, '0, '0, 1'b1);
        tick();
    endtask

    task automatic test_backpressure();
        drive(1'b1, 4'd7, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0);
        tick();
        drive(1'b1, 4'd4, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'hFFFF_FFFF ||
                {carryout, zero, overflow} !== 3'b000) begin
                $display("FAIL hold_stable[%0d]: got ov=%b ir=%b res=%h czv=%b%b%b want 1 0 ffffffff 000",
                         i, out_valid, in_ready, result, carryout, zero, overflow);
                n_err++;
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            $display("FAIL ready_follows_out_ready: got %b want 1", in_ready);
            n_err++;
        end
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || {result, carryout, zero, overflow} !== {32'h0F00_0F00, 3'b000}) begin
            $display("FAIL back_to_back_and: got ov=%b res=%h czv=%b%b%b want 1 0f000f00 000",
                     out_valid, result, carryout, zero, overflow);
            n_err++;
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_undefined();
        logic [3:0] first;
`ifdef SEQ_ALU_MUL_EN
        first = 4'd9;
`else
        first = 4'd8;
`endif
        for (int c = int'(first); c < 16; c++) begin
            drive(1'b1, 4'd2, 32'hFFFF_0000, 32'($urandom()) & 32'h0000_FFFF, 1'b1);
            tick();
            drive(1'b1, 4'(c), rand_op(), rand_op(), 1'b1);
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || {result, carryout, zero, overflow} !== {32'h0, 3'b010}) begin
                $display("FAIL undefined_op[%0d]: got ov=%b res=%h czv=%b%b%b want 1 0 010",
                         c, out_valid, result, carryout, zero, overflow);
                n_err++;
            end
        end
        drive(1'b0, 4'd0, '0, '0, 1'b1);
        tick();
    endtask

    task automatic test_reset_in_done();
        drive(1'b1, 4'd0, 32'd1, 32'd1, 1'b0);
        tick();
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, result, carryout, zero, overflow} !== '0) begin
            $display("FAIL reset_in_done: got ov=%b res=%h c=%b z=%b v=%b want all 0",
                     out_valid, result, carryout, zero, overflow);
            n_err++;
        end
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                $display("FAIL after_reset_done[%0d]: got ov=%b ir=%b want 0 1", i, out_valid, in_ready);
                n_err++;
            end
            tick();
        end
    endtask

`ifdef SEQ_ALU_MUL_EN
    task automatic test_mul();
        logic [W-1:0] va[2];
        logic [W-1:0] vb[2];
        logic [W+2:0] want[2];
        int cyc;
        bit ready_seen;
        va[0] = 32'h0001_0000; vb[0] = 32'h0001_0000; want[0] = {32'd0, 3'b011};
        va[1] = 32'd7;         vb[1] = 32'd6;         want[1] = {32'd42, 3'b000};
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 4'd8, va[k], vb[k], 1'b0);
            tick();
            drive(1'b1, 4'd0, 32'd1, 32'd1, 1'b0);
            cyc = 0;
            ready_seen = 1'b0;
            while (out_valid !== 1'b1 && cyc < 40) begin
                if (in_ready !== 1'b0) ready_seen = 1'b1;
                tick();
                cyc++;
            end
            n_cmp++;
            if (cyc != 32 || ready_seen) begin
                $display("FAIL mul_latency[%0d]: got %0d cycles ready_in_busy=%b want 32 0",
                         k, cyc, ready_seen);
                n_err++;
            end
            n_cmp++;
            if ({result, carryout, zero, overflow} !== want[k]) begin
                $display("FAIL mul_result[%0d]: got %h want %h", k,
                         {result, carryout, zero, overflow}, want[k]);
                n_err++;
            end
            drive(1'b0, 4'd0, '0, '0, 1'b1);
            tick();
        end
    endtask

    task automatic test_reset_mid_mul();
        drive(1'b1, 4'd8, 32'd1234, 32'd5678, 1'b1);
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, result, carryout, zero, overflow} !== '0) begin
            $display("FAIL reset_mid_mul: got ov=%b res=%h c=%b z=%b v=%b want all 0",
                     out_valid, result, carryout, zero, overflow);
            n_err++;
        end
        tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            $display("FAIL ready_after_mul_reset: got %b want 1", in_ready);
            n_err++;
        end
        for (int i = 0; i < 40; i++) begin
            n_cmp++;
            if (out_valid !== 1'b0) begin
                $display("FAIL stale_mul_result[%0d]: got out_valid=%b want 0", i, out_valid);
                n_err++;
            end
            tick();
        end
    endtask
`endif

    // Timing model: each accepted op becomes visible after a fixed number of edges.
    task automatic test_random();
        bit          inflight;
        int          done_cyc;
        int          cyc;
        bit          exp_ov;
        bit          exp_ir;
        logic [W+2:0] got;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        inflight = 1'b0;
        done_cyc = 0;
        cyc = 0;
        exp_q.delete();
        for (int i = 0; i < 450; i++) begin
            if (i < 400)
                drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), rand_op(), rand_op(),
                      1'($urandom_range(0, 2) != 0));
            else
                drive(1'b0, 4'd0, '0, '0, 1'b1);
            @(negedge clk);
            exp_ov = inflight && (cyc >= done_cyc);
            exp_ir = !inflight || (exp_ov && out_ready);
            n_cmp++;
            if (out_valid !== exp_ov || in_ready !== exp_ir) begin
                $display("FAIL rand_handshake@%0d: got ov=%b ir=%b want %b %b",
                         cyc, out_valid, in_ready, exp_ov, exp_ir);
                n_err++;
            end
            if (exp_ov) begin
                got = {result, carryout, zero, overflow};
                n_cmp++;
                if (exp_q.size() == 0 || got !== exp_q[0]) begin
                    $display("FAIL rand_result@%0d: got %h want %h", cyc, got,
                             (exp_q.size() == 0) ? '0 : exp_q[0]);
                    n_err++;
                end
                if (out_ready) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    inflight = 1'b0;
                end
            end
            if (in_valid && exp_ir) begin
                exp_q.push_back(model(command, operandA, operandB));
                inflight = 1'b1;
                done_cyc = cyc + 1;
`ifdef SEQ_ALU_MUL_EN
                if (command == 4'd8) done_cyc = cyc + 32;
`endif
            end
            tick();
            cyc++;
        end
        n_cmp++;
        if (exp_q.size() != 0 || inflight) begin
            $display("FAIL rand_drain: got %0d pending want 0", exp_q.size());
            n_err++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_slt();
        test_backpressure();
        test_undefined();
        test_reset_in_done();
`ifdef SEQ_ALU_MUL_EN
        test_mul();
        test_reset_mid_mul();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
